// File: rtl/sqrt_arbiter_pkg.sv
// Shared definitions for the square-root core arbiter: core widths, default
// timing, FSM state encoding and a small width helper.
package sqrt_arbiter_pkg;

    // Native widths of the tilt square-root core (x_in / x_out).
    localparam int SQRT_IN_W        = 22;
    localparam int SQRT_OUT_W       = 12;

    // Minimum cycles after issue before the core's ready flag is trusted,
    // and the cycle count at which an unanswered operation is abandoned.
    localparam int SQRT_LAT_DEF     = 16;
    localparam int SQRT_TIMEOUT_DEF = 64;

    // Operation sequencer states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Width of an index into n items; never narrower than one bit so a
    // single-requester build still has a legal (constant zero) pointer.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sqrt_arbiter_rr.sv
// Combinational round-robin grant logic. The pointer names the requester with
// the highest priority this cycle; the pointer register itself lives in the
// parent so this block stays purely combinational.
module sqrt_arbiter_rr
    import sqrt_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    // Scan from the pointer upward with wrap-around and grant the first
    // pending request; later hits are masked once one has been found.
    always_comb begin
        logic [PW-1:0] idx;
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Time-shares one square-root core between NUM_REQ requesters. One operation
// is in flight at a time: the winner's radicand is registered onto the core
// input and held, the core's ready flag is ignored for the first SQRT_LAT
// cycles (it may still show the previous result), and an operation that gets
// no answer by TIMEOUT cycles is returned with an error flag instead.
module sqrt_arbiter
    import sqrt_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int IN_W     = SQRT_IN_W,
    parameter int OUT_W    = SQRT_OUT_W,
    parameter int SQRT_LAT = SQRT_LAT_DEF,
    parameter int TIMEOUT  = SQRT_TIMEOUT_DEF,
    parameter int CNT_W    = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic [NUM_REQ-1:0]      res_valid,
    output logic [OUT_W-1:0]        res_data,
    output logic                    res_err,
    output logic                    busy,
    output logic                    err_timeout,
    output logic [IN_W-1:0]         sqrt_in,
    input  logic [OUT_W-1:0]        sqrt_out,
    input  logic                    sqrt_ready
);

    localparam int               PTR_W    = idx_w(NUM_REQ);
    localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(SQRT_LAT);
    localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REQ - 1);

    state_e               state_q,       state_d;
    logic [PTR_W-1:0]     ptr_q,         ptr_d;
    logic [CNT_W-1:0]     cnt_q,         cnt_d;
    logic [PTR_W-1:0]     tag_q,         tag_d;
    logic [IN_W-1:0]      sqrt_in_q,     sqrt_in_d;
    logic [NUM_REQ-1:0]   res_valid_q,   res_valid_d;
    logic [OUT_W-1:0]     res_data_q,    res_data_d;
    logic                 res_err_q,     res_err_d;
    logic                 err_timeout_q, err_timeout_d;

    logic [NUM_REQ-1:0]   grant;
    logic                 grant_any;
    logic [PTR_W-1:0]     grant_idx;
    logic [IN_W-1:0]      grant_data;

    sqrt_arbiter_rr #(
        .N     (NUM_REQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .any   (grant_any)
    );

    // Turn the one-hot grant into an index and select that requester's radicand.
    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx  = PTR_W'(i);
                grant_data = req_data[i*IN_W +: IN_W];
            end
        end
    end

    // Sequencer: accept in IDLE, then count in WAIT until the core answers
    // (after the blind window) or the timeout expires. Capture beats timeout
    // when both fall on the same cycle.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        sqrt_in_d     = sqrt_in_q;
        res_valid_d   = '0;
        res_data_d    = res_data_q;
        res_err_d     = 1'b0;
        err_timeout_d = err_timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    sqrt_in_d = grant_data;
                    tag_d     = grant_idx;
                    cnt_d     = '0;
                    ptr_d     = (grant_idx == LAST_PTR) ? '0 : grant_idx + 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != TO_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if ((cnt_q >= LAT_CNT) && sqrt_ready) begin
                    res_data_d  = sqrt_out;
                    res_valid_d = NUM_REQ'(1) << tag_q;
                    res_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else if (cnt_q == TO_CNT) begin
                    res_data_d    = '0;
                    res_valid_d   = NUM_REQ'(1) << tag_q;
                    res_err_d     = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            tag_q         <= '0;
            sqrt_in_q     <= '0;
            res_valid_q   <= '0;
            res_data_q    <= '0;
            res_err_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            tag_q         <= tag_d;
            sqrt_in_q     <= sqrt_in_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_err_q     <= res_err_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // The grant is only an acknowledge while idle and out of reset; a
    // request held during reset must not look accepted.
    assign req_ack     = ((state_q == ST_IDLE) && !reset) ? grant : '0;
    assign busy        = (state_q == ST_WAIT);
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;
    assign err_timeout = err_timeout_q;
    assign sqrt_in     = sqrt_in_q;

endmodule
